reg_scoreboard: RTL and testbench

- Tracks in-flight writes to the 32-entry MIPS register file. The decode stage reads register operands, and this block issues operands only when no older write to them is outstanding.
- Decode side: decode presents an instruction's source and destination registers. The block grants issue only when no source has an older write still pending.
- Writeback side: the block monitors the same writeback signals that drive the register file write port (write enable, destination address) and retires pending writes from them.
- Kill side: a squash port lets branch/flush logic cancel writes from killed instructions.

---
 rtl/reg_scoreboard.sv | 129 ++++++++++++
 tb/tb_reg_scoreboard.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes so decode issues
// an instruction only when none of its source operands is still pending.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   iss_valid              decode presents an instruction
//   iss_rs/iss_use_rs      source A and its use flag
//   iss_rt/iss_use_rt      source B and its use flag
//   iss_we/iss_rd          instruction writes register iss_rd
//   iss_ready              issue permitted this cycle (combinational)
//   wb_we/wb_rd            register-file write port, retires a pending write
//   kill_we/kill_rd        squash, cancels one pending write
//   busy_mask              registered, bit i set when register i has pending writes
//   pend_total             registered sum of all pending writes, saturating
//   err_underflow          sticky, a retire found no pending write to remove
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs,
  input  logic [4:0]      iss_rt,
  input  logic            iss_use_rs,
  input  logic            iss_use_rt,
  input  logic            iss_we,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic            kill_we,
  input  logic [4:0]      kill_rd,
  output logic [NREG-1:0] busy_mask,
  output logic [6:0]      pend_total,
  output logic            err_underflow
);

  localparam int SUM_RAW = CNT_W + $clog2(NREG) + 1;
  localparam int SUM_W   = (SUM_RAW > 8) ? SUM_RAW : 8;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] eff     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  uf;
  logic [NREG-1:0]  busy_nxt;
  logic [SUM_W-1:0] sum;
  logic [6:0]       pend_nxt;

  logic hz_rs;
  logic hz_rt;
  logic full;
  logic fire;

  // Counter after this cycle's retires, floored at zero. A retire
  // exceeding the count is an underflow; r0 is never tracked.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic           wb_hit;
      logic           kill_hit;
      logic [CNT_W:0] ret;
      logic [CNT_W:0] cur;
      wb_hit   = wb_we && (wb_rd == 5'(r));
      kill_hit = kill_we && (kill_rd == 5'(r));
      ret      = (CNT_W+1)'(wb_hit) + (CNT_W+1)'(kill_hit);
      cur      = {1'b0, cnt[r]};
      eff[r]   = '0;
      uf[r]    = 1'b0;
      if (r != 0) begin
        if (ret > cur) begin
          uf[r] = 1'b1;
        end else begin
          eff[r] = CNT_W'(cur - ret);
        end
      end
    end
  end

  // A write retiring this cycle is already visible to the operand read,
  // so hazards look at the post-retire count.
  always_comb begin
    hz_rs = iss_use_rs && (iss_rs != 5'd0) && (eff[iss_rs] != '0);
    hz_rt = iss_use_rt && (iss_rt != 5'd0) && (eff[iss_rt] != '0);
    full  = iss_we && (iss_rd != 5'd0) && (eff[iss_rd] == CMAX);
  end

  assign iss_ready = !rst && !hz_rs && !hz_rt && !full;
  assign fire      = iss_valid && iss_ready;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = eff[r];
      if (r != 0 && fire && iss_we && iss_rd == 5'(r)) begin
        cnt_nxt[r] = eff[r] + CNT_W'(1);
      end
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < NREG; r++) begin
      sum = sum + SUM_W'(cnt_nxt[r]);
    end
    pend_nxt = (sum > SUM_W'(127)) ? 7'd127 : sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      busy_mask     <= '0;
      pend_total    <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      busy_mask  <= busy_nxt;
      pend_total <= pend_nxt;
      if (|uf) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors against reg_scoreboard.
// Inputs change 1 time unit after posedge; outputs are read before the next edge.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs;
  logic [4:0]  iss_rt;
  logic        iss_use_rs;
  logic        iss_use_rt;
  logic        iss_we;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        kill_we;
  logic [4:0]  kill_rd;
  logic [31:0] busy_mask;
  logic [6:0]  pend_total;
  logic        err_underflow;

  int checks;
  int failures;

  reg_scoreboard #(
    .NREG(32),
    .CNT_W(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_rs       (iss_rs),
    .iss_rt       (iss_rt),
    .iss_use_rs   (iss_use_rs),
    .iss_use_rt   (iss_use_rt),
    .iss_we       (iss_we),
    .iss_rd       (iss_rd),
    .iss_ready    (iss_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .kill_we      (kill_we),
    .kill_rd      (kill_rd),
    .busy_mask    (busy_mask),
    .pend_total   (pend_total),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    iss_valid  = 1'b0;
    iss_rs     = '0;
    iss_rt     = '0;
    iss_use_rs = 1'b0;
    iss_use_rt = 1'b0;
    iss_we     = 1'b0;
    iss_rd     = '0;
    wb_we      = 1'b0;
    wb_rd      = '0;
    kill_we    = 1'b0;
    kill_rd    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd);
    clr();
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_rd    = rd;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    rst       = 1'b1;
    iss_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(iss_ready), 32'd0);
    cyc();
    cyc();
    chk("rst_ready1", 32'(iss_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_pend", 32'(pend_total), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_ready_rel", 32'(iss_ready), 32'd1);

    // RAW stall on r5
    wr(5'd5);
    #1;
    chk("raw_wr_ready", 32'(iss_ready), 32'd1);
    cyc();
    clr();
    iss_valid  = 1'b1;
    iss_use_rs = 1'b1;
    iss_rs     = 5'd5;
    #1;
    chk("raw_stall", 32'(iss_ready), 32'd0);
    chk("raw_busy5", 32'(busy_mask[5]), 32'd1);
    chk("raw_pend1", 32'(pend_total), 32'd1);
    wb_we = 1'b1;
    wb_rd = 5'd5;
    #1;
    chk("raw_wb_ready", 32'(iss_ready), 32'd1);
    cyc();
    clr();
    #1;
    chk("raw_busy5_clr", 32'(busy_mask[5]), 32'd0);
    chk("raw_pend0", 32'(pend_total), 32'd0);

    // Same-cycle issue and retire on r7
    wr(5'd7);
    cyc();
    wr(5'd7);
    wb_we = 1'b1;
    wb_rd = 5'd7;
    #1;
    chk("same_ready", 32'(iss_ready), 32'd1);
    cyc();
    clr();
    #1;
    chk("same_pend", 32'(pend_total), 32'd1);
    chk("same_busy", busy_mask, 32'h0000_0080);
    wb_we = 1'b1;
    wb_rd = 5'd7;
    cyc();
    clr();
    #1;
    chk("same_drain", 32'(pend_total), 32'd0);

    // Saturation on r9
    for (int i = 0; i < 3; i++) begin
      wr(5'd9);
      cyc();
    end
    clr();
    #1;
    chk("sat_pend3", 32'(pend_total), 32'd3);
    iss_rt = 5'd9;
    #1;
    chk("rt_unused", 32'(iss_ready), 32'd1);
    iss_use_rt = 1'b1;
    #1;
    chk("rt_hazard", 32'(iss_ready), 32'd0);
    wr(5'd9);
    #1;
    chk("sat_full", 32'(iss_ready), 32'd0);
    cyc();
    chk("sat_hold", 32'(pend_total), 32'd3);
    wb_we = 1'b1;
    wb_rd = 5'd9;
    #1;
    chk("sat_retire_ready", 32'(iss_ready), 32'd1);
    cyc();
    clr();
    #1;
    chk("sat_pend_stay", 32'(pend_total), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wb_we = 1'b1;
      wb_rd = 5'd9;
      cyc();
    end
    clr();
    #1;
    chk("sat_drain", 32'(pend_total), 32'd0);
    chk("sat_err", 32'(err_underflow), 32'd0);

    // r0 is never tracked and never errors
    wr(5'd0);
    iss_use_rs = 1'b1;
    iss_use_rt = 1'b1;
    wb_we      = 1'b1;
    kill_we    = 1'b1;
    #1;
    chk("r0_ready", 32'(iss_ready), 32'd1);
    cyc();
    clr();
    #1;
    chk("r0_busy", busy_mask, 32'd0);
    chk("r0_pend", 32'(pend_total), 32'd0);
    chk("r0_err", 32'(err_underflow), 32'd0);

    // Kill plus writeback on r12, count 2
    wr(5'd12);
    cyc();
    wr(5'd12);
    cyc();
    clr();
    #1;
    chk("kw_pend2", 32'(pend_total), 32'd2);
    wb_we   = 1'b1;
    wb_rd   = 5'd12;
    kill_we = 1'b1;
    kill_rd = 5'd12;
    cyc();
    clr();
    #1;
    chk("kw_busy12", 32'(busy_mask[12]), 32'd0);
    chk("kw_pend0", 32'(pend_total), 32'd0);
    chk("kw_noerr", 32'(err_underflow), 32'd0);

    // Kill plus writeback on r12, count 1
    wr(5'd12);
    cyc();
    clr();
    wb_we   = 1'b1;
    wb_rd   = 5'd12;
    kill_we = 1'b1;
    kill_rd = 5'd12;
    cyc();
    clr();
    #1;
    chk("kw1_pend0", 32'(pend_total), 32'd0);
    chk("kw1_busy", busy_mask, 32'd0);
    chk("kw1_err", 32'(err_underflow), 32'd1);

    // Underflow from a plain writeback, sticky until reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("uf_pre", 32'(err_underflow), 32'd0);
    wb_we = 1'b1;
    wb_rd = 5'd4;
    cyc();
    clr();
    #1;
    chk("uf_set", 32'(err_underflow), 32'd1);
    chk("uf_pend", 32'(pend_total), 32'd0);
    cyc();
    cyc();
    chk("uf_sticky", 32'(err_underflow), 32'd1);
    kill_we = 1'b1;
    kill_rd = 5'd3;
    rst     = 1'b1;
    cyc();
    rst = 1'b0;
    clr();
    #1;
    chk("uf_rst", 32'(err_underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
